// File: rtl/config_loader.sv
// config_loader
//   Producer end of the logic-tile configuration bus. Collects a bitstream of
//   WORD_WIDTH-bit words (valid/ready) LSB-first into a shadow register and
//   commits it atomically to config_out, so the tile never sees a partial load.
// Ports
//   clock, reset   : single clock, synchronous active-high reset
//   start          : one-cycle pulse, begins or restarts a load
//   data_in        : bitstream word
//   data_valid     : data_in holds a valid word
//   data_ready     : loader accepts a word this cycle (LOAD only)
//   busy           : 1 while loading
//   word_count     : words accepted in the current load
//   config_valid   : config_out holds a complete committed configuration
//   config_out     : parallel configuration to the tile
module config_loader #(
  parameter int CONFIG_WIDTH = 146,
  parameter int WORD_WIDTH   = 8,
  localparam int NUM_WORDS   = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
  localparam int CW          = $clog2(NUM_WORDS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    busy,
  output logic [CW-1:0]           word_count,
  output logic                    config_valid,
  output logic [CONFIG_WIDTH-1:0] config_out
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state, state_next;
  logic [CONFIG_WIDTH-1:0] shadow, shadow_next;
  logic                    accept, last;

  // A start in LOAD wins over a same-cycle handshake: that word is dropped.
  assign accept = (state == LOAD) && data_valid && !start;
  assign last   = accept && (word_count == CW'(NUM_WORDS - 1));

  // One slice per word; the final slice is truncated so pad bits of the last
  // word never reach the shadow register.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    localparam int LO = w * WORD_WIDTH;
    localparam int HI = (LO + WORD_WIDTH > CONFIG_WIDTH) ? CONFIG_WIDTH : LO + WORD_WIDTH;
    assign shadow_next[HI-1:LO] = (accept && word_count == CW'(w))
                                  ? data_in[HI-LO-1:0] : shadow[HI-1:LO];
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      shadow     <= '0;
      config_out <= '0;
      word_count <= '0;
    end else begin
      state  <= state_next;
      shadow <= shadow_next;
      if (start)       word_count <= '0;
      else if (accept) word_count <= word_count + 1'b1;
      // Commit includes the word accepted on this same edge.
      if (last)        config_out <= shadow_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (start) state_next = LOAD;
               else if (last) state_next = DONE;
      DONE:    if (start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    data_ready   = 1'b0;
    busy         = 1'b0;
    config_valid = 1'b0;
    unique case (state)
      LOAD:    begin data_ready = 1'b1; busy = 1'b1; end
      DONE:    config_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
